// File: rtl/lisnoc_router_vc_scheduler.sv
// Output-port VC scheduler: credit-gated round-robin pick of one VC per cycle onto a shared link,
// with optional packet locking (HEADER..LAST) and a sticky credit-overflow flag.
module lisnoc_router_vc_scheduler #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int vchannels       = 3,
    parameter int credits         = 4,
    parameter int lock_packets    = 0
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [(flit_data_width+flit_type_width)*vchannels-1:0] flit_i,
    input  logic [vchannels-1:0]                                valid_i,
    output logic [vchannels-1:0]                                ready_o,
    output logic [flit_data_width+flit_type_width-1:0]          flit_o,
    output logic [vchannels-1:0]                                valid_o,
    input  logic [vchannels-1:0]                                credit_i,
    output logic                                                error_o
);
    localparam int FW = flit_data_width + flit_type_width;
    localparam int CW = $clog2(credits + 1);
    localparam int IW = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam logic [flit_type_width-1:0] TYPE_HEADER = flit_type_width'(2'b01);
    localparam logic [flit_type_width-1:0] TYPE_LAST   = flit_type_width'(2'b10);

    logic [CW-1:0]          cnt_q [vchannels];
    logic [CW-1:0]          cnt_d [vchannels];
    logic [IW-1:0]          last_q, last_d;
    logic                   locked_q, locked_d;
    logic [IW-1:0]          lock_vc_q, lock_vc_d;
    logic [FW-1:0]          flit_q, flit_d;
    logic [vchannels-1:0]   valid_q, valid_d;
    logic                   error_q, error_d;

    logic [vchannels-1:0]   elig;
    logic                   grant_vld;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          cand;
    logic [FW-1:0]          grant_flit;
    logic [flit_type_width-1:0] grant_type;

    // While a packet holds the link, every VC other than the owner is masked out.
    always_comb begin
        elig = '0;
        for (int v = 0; v < vchannels; v++) begin
            elig[v] = valid_i[v] && (cnt_q[v] != '0) &&
                      (!locked_q || (lock_vc_q == IW'(v)));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < vchannels; i++) begin
            cand = IW'((int'(last_q) + 1 + i) % vchannels);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) begin
            grant_vld = 1'b0;
        end
    end

    assign grant_flit = flit_i[grant_idx*FW +: FW];
    assign grant_type = grant_flit[FW-1 -: flit_type_width];

    always_comb begin
        ready_o = '0;
        for (int v = 0; v < vchannels; v++) begin
            ready_o[v] = grant_vld && (grant_idx == IW'(v));
        end
    end

    always_comb begin
        last_d    = grant_vld ? grant_idx : last_q;
        locked_d  = locked_q;
        lock_vc_d = lock_vc_q;
        flit_d    = grant_vld ? grant_flit : flit_q;
        valid_d   = ready_o;
        error_d   = error_q;
        for (int v = 0; v < vchannels; v++) begin
            cnt_d[v] = cnt_q[v];
        end

        if ((lock_packets != 0) && grant_vld) begin
            if (grant_type == TYPE_HEADER) begin
                locked_d  = 1'b1;
                lock_vc_d = grant_idx;
            end else if (grant_type == TYPE_LAST) begin
                locked_d  = 1'b0;
            end
        end

        // A credit on a full counter is a protocol violation: saturate and flag.
        for (int v = 0; v < vchannels; v++) begin
            if (credit_i[v] && !ready_o[v]) begin
                if (cnt_q[v] == CW'(credits)) begin
                    error_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CW'(1);
                end
            end else if (!credit_i[v] && ready_o[v]) begin
                cnt_d[v] = cnt_q[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < vchannels; v++) begin
                cnt_q[v] <= CW'(credits);
            end
            last_q    <= IW'(vchannels - 1);
            locked_q  <= 1'b0;
            lock_vc_q <= '0;
            flit_q    <= '0;
            valid_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            for (int v = 0; v < vchannels; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
            last_q    <= last_d;
            locked_q  <= locked_d;
            lock_vc_q <= lock_vc_d;
            flit_q    <= flit_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign flit_o  = flit_q;
    assign valid_o = valid_q;
    assign error_o = error_q;
endmodule

// File: tb/tb_lisnoc_router_vc_scheduler.sv
// Bench for the VC scheduler: one unlocked and one packet-locking instance share the stimulus;
// grants are checked live, link outputs come off a scoreboard one cycle later.
module tb_lisnoc_router_vc_scheduler;
    localparam int FW = 34;

    logic            clk = 1'b0;
    logic            rst;
    logic [3*FW-1:0] flit_i;
    logic [2:0]      valid_i;
    logic [2:0]      credit_i;

    logic [2:0]      ready_nl, valid_nl, ready_lk, valid_lk;
    logic [FW-1:0]   flit_nl, flit_lk;
    logic            err_nl, err_lk;

    lisnoc_router_vc_scheduler #(.lock_packets(0)) dut_nl (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_nl),
        .flit_o(flit_nl), .valid_o(valid_nl), .credit_i(credit_i), .error_o(err_nl)
    );

    lisnoc_router_vc_scheduler #(.lock_packets(1)) dut_lk (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_lk),
        .flit_o(flit_lk), .valid_o(valid_lk), .credit_i(credit_i), .error_o(err_lk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    v0;
        logic [FW-1:0] f0;
        logic [2:0]    v1;
        logic [FW-1:0] f1;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            seq    = 0;
    logic [1:0]    ty [3];
    logic [FW-1:0] fl [3];
    logic [FW-1:0] pf0 = '0;
    logic [FW-1:0] pf1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [2:0] e);
        return e[0] ? 0 : (e[1] ? 1 : 2);
    endfunction

    // One clock: drive inputs, check grants mid-cycle, queue the expected link state, check it after the edge.
    task automatic cyc(input logic r, input logic [2:0] v, input logic [2:0] cr,
                       input logic [2:0] e_nl, input logic [2:0] e_lk, input logic err);
        exp_t e;
        rst      = r;
        valid_i  = v;
        credit_i = cr;
        for (int k = 0; k < 3; k++) begin
            fl[k] = {ty[k], 32'((seq << 4) | k)};
        end
        flit_i = {fl[2], fl[1], fl[0]};
        seq++;

        @(negedge clk);
        chk("ready_nolock", 64'(ready_nl), 64'(e_nl));
        chk("ready_lock", 64'(ready_lk), 64'(e_lk));
        e.v0  = r ? 3'b000 : e_nl;
        e.f0  = r ? '0 : ((e_nl != 3'b000) ? fl[oh_idx(e_nl)] : pf0);
        e.v1  = r ? 3'b000 : e_lk;
        e.f1  = r ? '0 : ((e_lk != 3'b000) ? fl[oh_idx(e_lk)] : pf1);
        e.err = err;
        pf0   = e.f0;
        pf1   = e.f1;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("valid_o_nolock", 64'(valid_nl), 64'(e.v0));
        chk("flit_o_nolock", 64'(flit_nl), 64'(e.f0));
        chk("valid_o_lock", 64'(valid_lk), 64'(e.v1));
        chk("flit_o_lock", 64'(flit_lk), 64'(e.f1));
        chk("error_nolock", 64'(err_nl), 64'(e.err));
        chk("error_lock", 64'(err_lk), 64'(e.err));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) ty[k] = 2'b00;

        // Reset: grants forced low, link and error cleared.
        cyc(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
        cyc(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);

        // Round-robin with credits echoed on each send.
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 3'b111, 3'(1 << (k % 3)), 3'(1 << (k % 3)), 3'(1 << (k % 3)), 1'b0);
        end

        // Credit exhaustion on VC0, then one returned credit buys one grant the next cycle.
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b001, 3'b000, 3'b001, 3'b001, 1'b0);
        cyc(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        cyc(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        cyc(1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
        cyc(1'b0, 3'b001, 3'b000, 3'b001, 3'b001, 1'b0);
        cyc(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);

        // VC1 down to one credit, then grant and credit in the same cycle.
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b010, 3'b000, 3'b010, 3'b010, 1'b0);
        cyc(1'b0, 3'b010, 3'b010, 3'b010, 3'b010, 1'b0);
        cyc(1'b0, 3'b010, 3'b000, 3'b010, 3'b010, 1'b0);
        cyc(1'b0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0);

        // Refill VC0 and VC1 to exactly full.
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0);

        // Overflow on full VC2: error sticks, counter stays at four credits.
        cyc(1'b0, 3'b000, 3'b100, 3'b000, 3'b000, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b100, 3'b000, 3'b100, 3'b100, 1'b1);
        cyc(1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 1'b1);

        // Packet lock: VC0 HEADER/PAYLOAD/LAST with VC1 always ready to send.
        ty[0] = 2'b01; cyc(1'b0, 3'b011, 3'b000, 3'b001, 3'b001, 1'b1);
        ty[0] = 2'b00; cyc(1'b0, 3'b011, 3'b000, 3'b010, 3'b001, 1'b1);
        ty[0] = 2'b10; cyc(1'b0, 3'b011, 3'b000, 3'b001, 3'b001, 1'b1);
        ty[0] = 2'b00; cyc(1'b0, 3'b011, 3'b000, 3'b010, 3'b010, 1'b1);
        // SINGLE must not lock.
        ty[0] = 2'b11; cyc(1'b0, 3'b011, 3'b000, 3'b001, 3'b001, 1'b1);
        ty[0] = 2'b00; cyc(1'b0, 3'b011, 3'b000, 3'b010, 3'b010, 1'b1);

        // Reset in the middle of a locked VC0 packet holding one credit.
        cyc(1'b0, 3'b000, 3'b001, 3'b000, 3'b000, 1'b1);
        cyc(1'b0, 3'b000, 3'b001, 3'b000, 3'b000, 1'b1);
        ty[0] = 2'b01; cyc(1'b0, 3'b011, 3'b000, 3'b001, 3'b001, 1'b1);
        ty[0] = 2'b00; cyc(1'b1, 3'b011, 3'b000, 3'b000, 3'b000, 1'b0);
        cyc(1'b0, 3'b011, 3'b000, 3'b001, 3'b001, 1'b0);
        cyc(1'b0, 3'b011, 3'b000, 3'b010, 3'b010, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b001, 3'b000, 3'b001, 3'b001, 1'b0);
        cyc(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lisnoc_router_vc_scheduler.md
# lisnoc_router_vc_scheduler

Output-port virtual-channel scheduler for the LISNoC router. It sits between the per-VC output arbiters/FIFOs of one output port and the physical link, and picks one VC per cycle to drive the shared link. Selection is round-robin among VCs that hold a flit and own downstream credit. It keeps a credit counter per VC, and can optionally lock the link to one VC for a whole packet.

## Interface
Parameters:
- flit_data_width, 32, flit payload width
- flit_type_width, 2, flit type field width (MSBs of flit)
- vchannels, 3, number of virtual channels sharing the link (1..8)
- credits, 4, downstream buffer depth per VC (initial credit count)
- lock_packets, 0, 1 = hold grant on a VC from HEADER until LAST

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flit_i  in  (flit_data_width+flit_type_width)*vchannels  per-VC head flits, VC v at slice v
- valid_i  in  vchannels  per-VC flit available
- ready_o  out  vchannels  one-hot grant; flit of VC v consumed this cycle
- flit_o  out  flit_data_width+flit_type_width  registered link flit
- valid_o  out  vchannels  registered one-hot link valid (VC tag)
- credit_i  in  vchannels  per-VC credit return pulse, one credit per cycle per bit
- error_o  out  1  sticky credit-overflow flag

## Operation
- Flit type encoding: PAYLOAD 2'b00, HEADER 2'b01, LAST 2'b10, SINGLE 2'b11.
- Each VC v has a credit counter cnt[v]:
  - width $clog2(credits+1)
  - reset value credits
- Eligibility: eligible[v] = valid_i[v] & (cnt[v] != 0).
- Round-robin grant:
  - Search starts at (last_grant+1) mod vchannels and selects the first eligible VC.
  - last_grant updates only on a grant.
  - After reset, last_grant = vchannels-1, so VC0 has highest priority first.
- Lock (lock_packets=1 only):
  - A grant of a HEADER flit sets locked=1 and lock_vc=v.
  - While locked, only lock_vc may be granted; all other VCs wait even when eligible.
  - A grant on lock_vc of a LAST flit clears locked.
  - SINGLE and PAYLOAD flits do not change the lock.
  - With lock_packets=0, the lock logic is absent and every cycle is a free round-robin.
- Counter update per cycle: cnt[v] += credit_i[v] - (grant==v).
  - Simultaneous grant and credit on the same VC leaves cnt unchanged.
  - If credit_i[v] arrives while cnt[v]==credits and no grant on v: cnt holds at credits and error_o sets; it stays set until rst.
- No grant is issued when no VC is eligible. Then ready_o = 0 and valid_o deasserts the next cycle.

## Timing
- Grant is combinational from registered state (cnt, last_grant, locked, lock_vc) and the current valid_i. ready_o[v] = grant in the same cycle.
- flit_o and valid_o are registered: the flit granted in cycle N appears on the link in cycle N+1. flit_o holds its previous value when valid_o = 0.
- Credit effect: a credit_i pulse in cycle N makes the VC eligible in cycle N+1. Credits returned and spent in the same cycle take effect together.
- Sustained throughput is 1 flit/cycle across VCs. A single VC sustains 1 flit/cycle while cnt[v] > 0.
- Reset values:
  - ready_o 0 (forced during rst), valid_o 0, flit_o 0, error_o 0
  - cnt[v] = credits, locked 0
- Reset mid-packet: the lock is dropped and credits are restored. The in-flight link register is cleared, so valid_o = 0 the cycle after rst.

## Test plan
- **Round-robin:** vchannels=3, all valid_i=1, credit_i echoes each send -> ready_o sequence 001,010,100,001,...; valid_o follows one cycle later.
- **Credit exhaustion:** valid_i[0]=1 only, credits=4, no credit_i -> exactly 4 grants, then ready_o=0. A single credit_i[0] pulse -> exactly one more grant, in the next cycle.
- **Simultaneous credit and grant:** cnt[1]=1, VC1 granted while credit_i[1]=1 in the same cycle -> cnt[1] stays 1 and VC1 is granted again the next cycle.
- **Overflow:** credit_i[2] pulsed with cnt[2]=credits -> error_o=1 the next cycle, cnt[2] stays at credits, error_o stays set until rst.
- **Lock:** lock_packets=1, VC0 sends HEADER,PAYLOAD,LAST while VC1 is valid throughout -> grants 0,0,0 then 1. With lock_packets=0, the same stimulus alternates 0,1,0,1.
- **Reset mid-packet:** rst asserted during a locked VC0 packet with cnt[0]=1 -> next cycle valid_o=0, all cnt=credits, unlocked, VC0 granted first.
